pipelined_decoder: RTL

PIPELINED_DECODER -- requirements
Module: pipelined_decoder

---
 rtl/pipelined_decoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pipelined_decoder.sv
// Registered instruction decoder: one control word per accepted opcode, two for memory ops.
// Optional macro DECODER_TRAP_EN turns illegal opcodes into a sticky TRAP state cleared by trap_clr.
module pipelined_decoder #(
    parameter int OPCODE_W = 8,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [ADDR_W-1:0]   operand,
    output logic                ctrl_valid,
    output logic [2:0]          alu_sel,
    output logic                acc_sel,
    output logic [1:0]          alu_b_sel,
    output logic [1:0]          bank_out_sel,
    output logic [2:0]          source_reg_sel,
    output logic [NUM_REGS-1:0] destination_reg_flag,
    output logic                write,
    output logic [ADDR_W-1:0]   address,
    output logic [1:0]          state_control,
    output logic                illegal_op,
    input  logic                trap_clr
);

    typedef enum logic [2:0] {IDLE, EXEC, MEM_ADDR, MEM_DATA, TRAP} state_t;

    typedef struct packed {
        logic                ctrl_valid;
        logic [2:0]          alu_sel;
        logic                acc_sel;
        logic [1:0]          alu_b_sel;
        logic [1:0]          bank_out_sel;
        logic [2:0]          source_reg_sel;
        logic [NUM_REGS-1:0] dest;
        logic                write;
        logic [ADDR_W-1:0]   address;
        logic [1:0]          state_control;
        logic                illegal_op;
    } ctrl_t;

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [2:0] mem_op_q, mem_op_d;
    logic       accept;
    logic       legal;
    logic [4:0] op5;
    logic [3:0] arith_k;

    // Register indices beyond the bank size produce no write enable at all.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [2:0] idx);
        logic [NUM_REGS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 3'(i)) r[i] = 1'b1;
        end
        return r;
    endfunction

    assign in_ready = rst_n && (state_q == IDLE || state_q == EXEC || state_q == MEM_DATA);
    assign accept   = in_valid && in_ready;
    assign legal    = ~|opcode[OPCODE_W-1:5];
    assign op5      = opcode[4:0];
    // Wraps modulo 16, which maps 0x0C..0x17 onto 0..11.
    assign arith_k  = opcode[3:0] - 4'd12;

`ifndef DECODER_TRAP_EN
    logic unused_trap_clr;
    assign unused_trap_clr = trap_clr;
`endif

    always_comb begin
        state_d  = IDLE;
        ctrl_d   = '0;
        mem_op_d = mem_op_q;
        case (state_q)
            MEM_ADDR: begin
                state_d              = MEM_DATA;
                ctrl_d.ctrl_valid    = 1'b1;
                ctrl_d.state_control = 2'b10;
                ctrl_d.address       = ctrl_q.address;
                ctrl_d.bank_out_sel  = mem_op_q[1:0];
                ctrl_d.write         = mem_op_q[2];
                if (!mem_op_q[2]) ctrl_d.dest = onehot({1'b0, mem_op_q[1:0]});
            end
            TRAP: begin
`ifdef DECODER_TRAP_EN
                if (!trap_clr) begin
                    state_d           = TRAP;
                    ctrl_d.illegal_op = 1'b1;
                end
`endif
            end
            default: begin
                if (accept) begin
                    if (!legal) begin
`ifdef DECODER_TRAP_EN
                        state_d           = TRAP;
                        ctrl_d.illegal_op = 1'b1;
`else
                        state_d           = EXEC;
                        ctrl_d.ctrl_valid = 1'b1;
                        ctrl_d.illegal_op = 1'b1;
`endif
                    end else if (op5 < 5'd12) begin
                        state_d               = EXEC;
                        ctrl_d.ctrl_valid     = 1'b1;
                        ctrl_d.source_reg_sel = {1'b0, op5[1:0]};
                        ctrl_d.dest           = onehot({1'b0, op5[3:2]});
                        ctrl_d.acc_sel        = (op5[3:2] == 2'b00);
                    end else if (op5 < 5'd24) begin
                        state_d           = EXEC;
                        ctrl_d.ctrl_valid = 1'b1;
                        ctrl_d.alu_sel    = arith_k[3:1];
                        ctrl_d.alu_b_sel  = {1'b0, arith_k[0]};
                        ctrl_d.acc_sel    = 1'b1;
                        ctrl_d.dest       = onehot(3'd0);
                    end else begin
                        state_d              = MEM_ADDR;
                        ctrl_d.ctrl_valid    = 1'b1;
                        ctrl_d.state_control = 2'b01;
                        ctrl_d.address       = operand;
                        mem_op_d             = op5[2:0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_op_q <= mem_op_d;
    end

    assign ctrl_valid           = ctrl_q.ctrl_valid;
    assign alu_sel              = ctrl_q.alu_sel;
    assign acc_sel              = ctrl_q.acc_sel;
    assign alu_b_sel            = ctrl_q.alu_b_sel;
    assign bank_out_sel         = ctrl_q.bank_out_sel;
    assign source_reg_sel       = ctrl_q.source_reg_sel;
    assign destination_reg_flag = ctrl_q.dest;
    assign write                = ctrl_q.write;
    assign address              = ctrl_q.address;
    assign state_control        = ctrl_q.state_control;
    assign illegal_op           = ctrl_q.illegal_op;

endmodule
